// File: rtl/sram_arb_pkg.sv
// Shared definitions for the instruction SRAM port-0 arbiter:
// read tag encoding, default widths and a saturating counter helper.
package sram_arb_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 32;
  localparam int RD_LAT_DEF = 1;

  localparam logic [3:0] WMASK_ALL = 4'hF;

  // Owner of a read travelling through the SRAM latency pipeline
  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_FE   = 2'd1,
    TAG_DBG  = 2'd2
  } tag_e;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/sram_port_arbiter_if.sv
// Requester and SRAM-side signals of the port-0 arbiter.
// slave  : the arbiter itself.
// master : the surrounding loader / fetch / debug logic and the SRAM macro.
interface sram_port_arbiter_if
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);

  logic              ld_we;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_wdata;

  logic              fe_req;
  logic [ADDR_W-1:0] fe_addr;
  logic              fe_gnt;
  logic              fe_rvalid;
  logic [DATA_W-1:0] fe_rdata;

  logic              dbg_req;
  logic [ADDR_W-1:0] dbg_addr;
  logic              dbg_gnt;
  logic              dbg_rvalid;
  logic [DATA_W-1:0] dbg_rdata;

  logic              sram_csb0;
  logic              sram_web0;
  logic [3:0]        sram_wmask0;
  logic [ADDR_W-1:0] sram_addr0;
  logic [DATA_W-1:0] sram_din0;
  logic [DATA_W-1:0] sram_dout0;

  modport slave (
    input  ld_we, ld_addr, ld_wdata,
    input  fe_req, fe_addr,
    output fe_gnt, fe_rvalid, fe_rdata,
    input  dbg_req, dbg_addr,
    output dbg_gnt, dbg_rvalid, dbg_rdata,
    output sram_csb0, sram_web0, sram_wmask0, sram_addr0, sram_din0,
    input  sram_dout0
  );

  modport master (
    output ld_we, ld_addr, ld_wdata,
    output fe_req, fe_addr,
    input  fe_gnt, fe_rvalid, fe_rdata,
    output dbg_req, dbg_addr,
    input  dbg_gnt, dbg_rvalid, dbg_rdata,
    input  sram_csb0, sram_web0, sram_wmask0, sram_addr0, sram_din0,
    output sram_dout0
  );

endinterface

// File: rtl/sram_arb_tag_pipe.sv
// RD_LAT-deep shift register carrying the owner tag of each SRAM read,
// so the tail lines up with the cycle in which sram_dout0 is valid.
module sram_arb_tag_pipe
  import sram_arb_pkg::*;
#(
  parameter int RD_LAT = RD_LAT_DEF
) (
  input  logic clk,
  input  logic clr,
  input  tag_e tag_in,
  output tag_e tag_out
);

  tag_e stage [RD_LAT];

  // Shift tags one stage per cycle; clear drops every read in flight
  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < RD_LAT; i++) stage[i] <= TAG_NONE;
    end else begin
      stage[0] <= tag_in;
      for (int i = 1; i < RD_LAT; i++) stage[i] <= stage[i-1];
    end
  end

  assign tag_out = stage[RD_LAT-1];

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares port 0 of the 32x256 instruction SRAM between the UART loader
// (writes, never stalled), the FPU instruction fetch and a debug readback
// path (reads, round-robin). Reads are tagged and their data is routed
// back to the issuing requester RD_LAT cycles after the grant.
// Optional build macro: SRAM_ARB_STATS_EN adds per-requester stall counters.
module sram_port_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int RD_LAT = RD_LAT_DEF
) (
  input  logic               clk,
  input  logic               rst_l,
  sram_port_arbiter_if.slave bus
`ifdef SRAM_ARB_STATS_EN
  ,
  output logic [15:0]        fe_stall_cnt,
  output logic [15:0]        dbg_stall_cnt
`endif
);

  logic              fe_first;
  logic              fe_gnt_c;
  logic              dbg_gnt_c;
  logic              csb_c;
  logic              web_c;
  logic [ADDR_W-1:0] addr_c;
  logic [DATA_W-1:0] din_c;
  tag_e              tag_in;
  tag_e              tail_tag;
  logic              fe_hit;
  logic              dbg_hit;
  logic [DATA_W-1:0] fe_hold;
  logic [DATA_W-1:0] dbg_hold;

  // Grant decision: loader blocks all reads, otherwise round-robin on ties
  always_comb begin
    fe_gnt_c  = 1'b0;
    dbg_gnt_c = 1'b0;
    if (rst_l && !bus.ld_we) begin
      if (bus.fe_req && (fe_first || !bus.dbg_req)) fe_gnt_c = 1'b1;
      else if (bus.dbg_req)                          dbg_gnt_c = 1'b1;
    end
  end

  // SRAM port drive and read tag for the access chosen this cycle
  always_comb begin
    csb_c  = 1'b1;
    web_c  = 1'b1;
    addr_c = '0;
    din_c  = '0;
    tag_in = TAG_NONE;
    if (rst_l) begin
      if (bus.ld_we) begin
        csb_c  = 1'b0;
        web_c  = 1'b0;
        addr_c = bus.ld_addr;
        din_c  = bus.ld_wdata;
      end else if (fe_gnt_c) begin
        csb_c  = 1'b0;
        addr_c = bus.fe_addr;
        tag_in = TAG_FE;
      end else if (dbg_gnt_c) begin
        csb_c  = 1'b0;
        addr_c = bus.dbg_addr;
        tag_in = TAG_DBG;
      end
    end
  end

  // Round-robin pointer: the requester not granted last gets the next tie
  always_ff @(posedge clk) begin
    if (!rst_l)         fe_first <= 1'b1;
    else if (fe_gnt_c)  fe_first <= 1'b0;
    else if (dbg_gnt_c) fe_first <= 1'b1;
  end

  sram_arb_tag_pipe #(.RD_LAT(RD_LAT)) u_tag_pipe (
    .clk     (clk),
    .clr     (!rst_l),
    .tag_in  (tag_in),
    .tag_out (tail_tag)
  );

  assign fe_hit  = rst_l && (tail_tag == TAG_FE);
  assign dbg_hit = rst_l && (tail_tag == TAG_DBG);

  // Capture returning read data for its owner; the other side keeps its last word
  always_ff @(posedge clk) begin
    if (!rst_l) begin
      fe_hold  <= '0;
      dbg_hold <= '0;
    end else begin
      if (fe_hit)  fe_hold  <= bus.sram_dout0;
      if (dbg_hit) dbg_hold <= bus.sram_dout0;
    end
  end

  assign bus.fe_gnt      = fe_gnt_c;
  assign bus.dbg_gnt     = dbg_gnt_c;
  assign bus.fe_rvalid   = fe_hit;
  assign bus.dbg_rvalid  = dbg_hit;
  assign bus.fe_rdata    = !rst_l ? '0 : (fe_hit  ? bus.sram_dout0 : fe_hold);
  assign bus.dbg_rdata   = !rst_l ? '0 : (dbg_hit ? bus.sram_dout0 : dbg_hold);
  assign bus.sram_csb0   = csb_c;
  assign bus.sram_web0   = web_c;
  assign bus.sram_wmask0 = WMASK_ALL;
  assign bus.sram_addr0  = addr_c;
  assign bus.sram_din0   = din_c;

`ifdef SRAM_ARB_STATS_EN
  // Count cycles each requester waits without a grant, saturating at all-ones
  always_ff @(posedge clk) begin
    if (!rst_l) begin
      fe_stall_cnt  <= '0;
      dbg_stall_cnt <= '0;
    end else begin
      if (bus.fe_req && !fe_gnt_c)   fe_stall_cnt  <= sat_inc16(fe_stall_cnt);
      if (bus.dbg_req && !dbg_gnt_c) dbg_stall_cnt <= sat_inc16(dbg_stall_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Self-checking bench for sram_port_arbiter with a behavioural SRAM and a
// transaction-level reference model (shadow memory plus a queue of
// expected read responses). Build with SRAM_ARB_STATS_EN to cover the
// stall counters as well.
module tb_sram_port_arbiter;
  import sram_arb_pkg::*;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;
  localparam int RD_LAT = 2;

  logic clk = 1'b0;
  logic rst_l;
  logic preload;

  always #5 clk = ~clk;

  sram_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

`ifdef SRAM_ARB_STATS_EN
  logic [15:0] fe_stall_cnt;
  logic [15:0] dbg_stall_cnt;
`endif

  sram_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
    .clk   (clk),
    .rst_l (rst_l),
    .bus   (bus)
`ifdef SRAM_ARB_STATS_EN
    ,
    .fe_stall_cnt  (fe_stall_cnt),
    .dbg_stall_cnt (dbg_stall_cnt)
`endif
  );

  function automatic logic [31:0] init_word(input int a);
    if (a == 5) return 32'h0000_0013;
    return {8'hC0, a[7:0], ~a[7:0], a[7:0]};
  endfunction

  // Behavioural SRAM: synchronous access, data valid RD_LAT cycles later
  logic [31:0] sram_mem [256];
  logic [31:0] dly [RD_LAT];

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 256; i++) sram_mem[i] <= init_word(i);
    end else if (!bus.sram_csb0) begin
      if (!bus.sram_web0) sram_mem[bus.sram_addr0] <= bus.sram_din0;
      else                dly[0] <= sram_mem[bus.sram_addr0];
    end
    for (int i = 1; i < RD_LAT; i++) dly[i] <= dly[i-1];
  end

  assign bus.sram_dout0 = dly[RD_LAT-1];

  // Reference model state
  typedef struct {
    bit          is_fe;
    int          due;
    logic [31:0] data;
  } resp_t;

  resp_t       pend[$];
  logic [31:0] ref_mem [256];
  bit          last_was_fe;
  logic [31:0] fe_seen, dbg_seen;
  int          m_fe_stall, m_dbg_stall;
  int          cyc;
  int          total, bad;

  logic        obs_fe_gnt, obs_dbg_gnt, obs_csb, obs_web;
  logic        obs_fe_rvalid, obs_dbg_rvalid;
  logic [31:0] obs_fe_rdata, obs_dbg_rdata;

  task automatic check_word(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    check_word(name, 32'(act), 32'(exp));
  endtask

  // One clock cycle: check DUT outputs at negedge against the model, then advance
  task automatic cycle();
    logic        e_fe, e_dbg, e_acc, hit_fe, hit_dbg;
    logic [31:0] hit_data;
    resp_t       r;
    @(negedge clk);
    obs_fe_gnt     = bus.fe_gnt;
    obs_dbg_gnt    = bus.dbg_gnt;
    obs_csb        = bus.sram_csb0;
    obs_web        = bus.sram_web0;
    obs_fe_rvalid  = bus.fe_rvalid;
    obs_dbg_rvalid = bus.dbg_rvalid;
    obs_fe_rdata   = bus.fe_rdata;
    obs_dbg_rdata  = bus.dbg_rdata;

    e_fe  = 1'b0;
    e_dbg = 1'b0;
    if (rst_l && !bus.ld_we) begin
      if (bus.fe_req && bus.dbg_req) begin
        if (last_was_fe) e_dbg = 1'b1;
        else             e_fe  = 1'b1;
      end else if (bus.fe_req)  e_fe  = 1'b1;
      else if (bus.dbg_req)     e_dbg = 1'b1;
    end
    check_bit("fe_gnt", bus.fe_gnt, e_fe);
    check_bit("dbg_gnt", bus.dbg_gnt, e_dbg);

    e_acc = rst_l && (bus.ld_we || e_fe || e_dbg);
    check_bit("csb0", bus.sram_csb0, !e_acc);
    check_word("wmask0", 32'(bus.sram_wmask0), 32'hF);
    if (!rst_l) begin
      check_bit("web0_rst", bus.sram_web0, 1'b1);
      check_word("addr0_rst", 32'(bus.sram_addr0), 32'h0);
      check_word("din0_rst", bus.sram_din0, 32'h0);
    end else if (bus.ld_we) begin
      check_bit("web0_wr", bus.sram_web0, 1'b0);
      check_word("addr0_wr", 32'(bus.sram_addr0), 32'(bus.ld_addr));
      check_word("din0_wr", bus.sram_din0, bus.ld_wdata);
    end else if (e_fe) begin
      check_bit("web0_fe", bus.sram_web0, 1'b1);
      check_word("addr0_fe", 32'(bus.sram_addr0), 32'(bus.fe_addr));
    end else if (e_dbg) begin
      check_bit("web0_dbg", bus.sram_web0, 1'b1);
      check_word("addr0_dbg", 32'(bus.sram_addr0), 32'(bus.dbg_addr));
    end

    hit_fe   = 1'b0;
    hit_dbg  = 1'b0;
    hit_data = 32'h0;
    if (pend.size() > 0 && pend[0].due == cyc) begin
      if (rst_l) begin
        hit_fe   = pend[0].is_fe;
        hit_dbg  = !pend[0].is_fe;
        hit_data = pend[0].data;
      end
      pend.delete(0);
    end
    if (hit_fe)  fe_seen  = hit_data;
    if (hit_dbg) dbg_seen = hit_data;
    check_bit("fe_rvalid", bus.fe_rvalid, hit_fe);
    check_bit("dbg_rvalid", bus.dbg_rvalid, hit_dbg);
    check_word("fe_rdata", bus.fe_rdata, rst_l ? fe_seen : 32'h0);
    check_word("dbg_rdata", bus.dbg_rdata, rst_l ? dbg_seen : 32'h0);
`ifdef SRAM_ARB_STATS_EN
    check_word("fe_stall_cnt", 32'(fe_stall_cnt), m_fe_stall);
    check_word("dbg_stall_cnt", 32'(dbg_stall_cnt), m_dbg_stall);
`endif

    if (!rst_l) begin
      pend.delete();
      last_was_fe = 1'b0;
      fe_seen     = 32'h0;
      dbg_seen    = 32'h0;
      m_fe_stall  = 0;
      m_dbg_stall = 0;
    end else begin
      if (e_fe) begin
        r.is_fe = 1'b1; r.due = cyc + RD_LAT; r.data = ref_mem[bus.fe_addr];
        pend.push_back(r);
        last_was_fe = 1'b1;
      end
      if (e_dbg) begin
        r.is_fe = 1'b0; r.due = cyc + RD_LAT; r.data = ref_mem[bus.dbg_addr];
        pend.push_back(r);
        last_was_fe = 1'b0;
      end
      if (bus.ld_we) ref_mem[bus.ld_addr] = bus.ld_wdata;
      if (bus.fe_req && !e_fe && m_fe_stall < 65535)    m_fe_stall++;
      if (bus.dbg_req && !e_dbg && m_dbg_stall < 65535) m_dbg_stall++;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle_inputs();
    bus.ld_we    = 1'b0;
    bus.ld_addr  = 8'h00;
    bus.ld_wdata = 32'h0;
    bus.fe_req   = 1'b0;
    bus.fe_addr  = 8'h00;
    bus.dbg_req  = 1'b0;
    bus.dbg_addr = 8'h00;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_l = 1'b0;
    cycle();
    rst_l = 1'b1;
  endtask

  typedef struct {
    logic        ld_we;
    logic [7:0]  ld_addr;
    logic [31:0] ld_wdata;
    logic        fe_req;
    logic [7:0]  fe_addr;
    logic        dbg_req;
    logic [7:0]  dbg_addr;
    logic        x_fe_gnt;
    logic        x_dbg_gnt;
    logic        x_csb;
    logic        x_web;
  } vec_t;

  vec_t vecs [15];

  bit fe_pend, dbg_pend;

  initial begin
    total = 0; bad = 0; cyc = 0;
    last_was_fe = 1'b0; fe_seen = 32'h0; dbg_seen = 32'h0;
    m_fe_stall = 0; m_dbg_stall = 0;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);

    //                ld_we  ld_addr ld_wdata       fe  fe_addr dbg dbg_addr  gF    gD    csb   web
    vecs[0]  = '{1'b0, 8'h00, 32'h0,          1'b1, 8'h01, 1'b1, 8'h80, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[1]  = '{1'b0, 8'h00, 32'h0,          1'b1, 8'h02, 1'b1, 8'h80, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[2]  = '{1'b0, 8'h00, 32'h0,          1'b1, 8'h02, 1'b1, 8'h81, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[3]  = '{1'b0, 8'h00, 32'h0,          1'b1, 8'h03, 1'b1, 8'h81, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[4]  = '{1'b0, 8'h00, 32'h0,          1'b1, 8'h03, 1'b1, 8'h82, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[5]  = '{1'b0, 8'h00, 32'h0,          1'b1, 8'h04, 1'b1, 8'h82, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[6]  = '{1'b0, 8'h00, 32'h0,          1'b1, 8'h04, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[7]  = '{1'b1, 8'h10, 32'hDEADBEEF,   1'b1, 8'h10, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 8'h00, 32'h0,          1'b1, 8'h10, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[9]  = '{1'b1, 8'h20, 32'h12345678,   1'b0, 8'h00, 1'b1, 8'h40, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 8'h00, 32'h0,          1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[11] = '{1'b0, 8'h00, 32'h0,          1'b1, 8'h06, 1'b1, 8'h41, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[12] = '{1'b0, 8'h00, 32'h0,          1'b1, 8'h06, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[13] = '{1'b0, 8'h00, 32'h0,          1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[14] = '{1'b0, 8'h00, 32'h0,          1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1};

    // Reset with SRAM preload
    idle_inputs();
    rst_l   = 1'b0;
    preload = 1'b1;
    cycle();
    preload = 1'b0;
    cycle();
    check_bit("reset_csb", obs_csb, 1'b1);
    check_bit("reset_fe_rvalid", obs_fe_rvalid, 1'b0);
    rst_l = 1'b1;

    // Single fetch of word 5: grant same cycle, data RD_LAT cycles later
    bus.fe_req  = 1'b1;
    bus.fe_addr = 8'h05;
    cycle();
    check_bit("t1_fe_gnt", obs_fe_gnt, 1'b1);
    idle_inputs();
    for (int i = 1; i < RD_LAT; i++) begin
      cycle();
      check_bit("t1_early_rvalid", obs_fe_rvalid, 1'b0);
    end
    cycle();
    check_bit("t1_fe_rvalid", obs_fe_rvalid, 1'b1);
    check_word("t1_fe_rdata", obs_fe_rdata, 32'h0000_0013);
    cycle();
    check_bit("t1_rvalid_pulse", obs_fe_rvalid, 1'b0);

    // Table: alternation, loader priority, withdrawn debug request
    do_reset();
    for (int i = 0; i < 15; i++) begin
      bus.ld_we    = vecs[i].ld_we;
      bus.ld_addr  = vecs[i].ld_addr;
      bus.ld_wdata = vecs[i].ld_wdata;
      bus.fe_req   = vecs[i].fe_req;
      bus.fe_addr  = vecs[i].fe_addr;
      bus.dbg_req  = vecs[i].dbg_req;
      bus.dbg_addr = vecs[i].dbg_addr;
      cycle();
      check_bit("vec_fe_gnt", obs_fe_gnt, vecs[i].x_fe_gnt);
      check_bit("vec_dbg_gnt", obs_dbg_gnt, vecs[i].x_dbg_gnt);
      check_bit("vec_csb", obs_csb, vecs[i].x_csb);
      check_bit("vec_web", obs_web, vecs[i].x_web);
      if (i == 10) begin
        check_bit("raw_fe_rvalid", obs_fe_rvalid, 1'b1);
        check_word("raw_fe_rdata", obs_fe_rdata, 32'hDEADBEEF);
      end
      if (i == 11) check_bit("withdrawn_dbg_rvalid", obs_dbg_rvalid, 1'b0);
    end

    // Read in flight when its word is overwritten returns the old data
    bus.fe_req  = 1'b1;
    bus.fe_addr = 8'h30;
    cycle();
    idle_inputs();
    bus.ld_we    = 1'b1;
    bus.ld_addr  = 8'h30;
    bus.ld_wdata = 32'hCAFEF00D;
    cycle();
    idle_inputs();
    for (int i = 2; i < RD_LAT; i++) cycle();
    cycle();
    check_bit("inflight_rvalid", obs_fe_rvalid, 1'b1);
    check_word("inflight_old_data", obs_fe_rdata, init_word(8'h30));
    bus.dbg_req  = 1'b1;
    bus.dbg_addr = 8'h30;
    cycle();
    idle_inputs();
    for (int i = 0; i < RD_LAT; i++) cycle();
    check_word("new_data_dbg", obs_dbg_rdata, 32'hCAFEF00D);

    // Reset while a fetch is in flight: the read never completes
    bus.fe_req  = 1'b1;
    bus.fe_addr = 8'h07;
    cycle();
    idle_inputs();
    rst_l = 1'b0;
    cycle();
    check_bit("midrst_csb", obs_csb, 1'b1);
    check_bit("midrst_gnt", obs_fe_gnt, 1'b0);
    rst_l = 1'b1;
    for (int i = 0; i < RD_LAT + 1; i++) begin
      cycle();
      check_bit("midrst_no_rvalid", obs_fe_rvalid, 1'b0);
    end

    // Write-only traffic
    for (int i = 0; i < 4; i++) begin
      bus.ld_we    = 1'b1;
      bus.ld_addr  = 8'($urandom_range(64, 79));
      bus.ld_wdata = $urandom;
      cycle();
    end
    idle_inputs();
    for (int i = 0; i < RD_LAT + 1; i++) begin
      cycle();
      check_bit("wronly_fe_rvalid", obs_fe_rvalid, 1'b0);
      check_bit("wronly_dbg_rvalid", obs_dbg_rvalid, 1'b0);
    end

    // Randomized traffic with honest requesters and occasional resets
    fe_pend  = 1'b0;
    dbg_pend = 1'b0;
    for (int n = 0; n < 600; n++) begin
      rst_l        = ($urandom_range(0, 63) != 0);
      bus.ld_we    = ($urandom_range(0, 3) == 0);
      bus.ld_addr  = 8'($urandom_range(0, 15));
      bus.ld_wdata = $urandom;
      if (!fe_pend) begin
        if ($urandom_range(0, 2) != 0) begin
          fe_pend     = 1'b1;
          bus.fe_addr = 8'($urandom_range(0, 15));
        end
      end else if ($urandom_range(0, 15) == 0) fe_pend = 1'b0;
      if (!dbg_pend) begin
        if ($urandom_range(0, 2) != 0) begin
          dbg_pend     = 1'b1;
          bus.dbg_addr = 8'($urandom_range(0, 15));
        end
      end else if ($urandom_range(0, 15) == 0) dbg_pend = 1'b0;
      bus.fe_req  = fe_pend;
      bus.dbg_req = dbg_pend;
      cycle();
      if (obs_fe_gnt)  fe_pend  = 1'b0;
      if (obs_dbg_gnt) dbg_pend = 1'b0;
    end
    rst_l = 1'b1;
    idle_inputs();
    for (int i = 0; i < RD_LAT + 1; i++) cycle();

`ifdef SRAM_ARB_STATS_EN
    // Stall counters: three loader-blocked fetch cycles, then saturation
    do_reset();
    bus.ld_we    = 1'b1;
    bus.ld_addr  = 8'h01;
    bus.ld_wdata = 32'h0BAD_0001;
    bus.fe_req   = 1'b1;
    bus.fe_addr  = 8'h02;
    for (int i = 0; i < 3; i++) cycle();
    check_word("stall_cnt_3", 32'(fe_stall_cnt), 32'd3);
    for (int i = 0; i < 65532; i++) cycle();
    check_word("stall_cnt_full", 32'(fe_stall_cnt), 32'hFFFF);
    cycle();
    check_word("stall_cnt_sat", 32'(fe_stall_cnt), 32'hFFFF);
    idle_inputs();
    cycle();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
